// File: rtl/bcd_timer_modn.sv
// Two-digit BCD up/down counter modulo MODULUS with clear, range-checked preset,
// and a same-cycle carry/borrow for cascading timer stages.
module bcd_timer_modn #(
   parameter int MODULUS    = 60,
   parameter int HIGH_WIDTH = 3
) (
   input  logic                  clk_i,
   input  logic                  reset_ni,
   input  logic                  enable_i,
   input  logic                  up_down_i,
   input  logic                  clear_i,
   input  logic                  load_i,
   input  logic [3:0]            load_low_i,
   input  logic [HIGH_WIDTH-1:0] load_high_i,
   output logic [3:0]            low_digit_o,
   output logic [HIGH_WIDTH-1:0] high_digit_o,
   output logic                  at_terminal_o,
   output logic                  carry_out_o,
   output logic                  load_err_o
);

   localparam logic [HIGH_WIDTH-1:0] MAX_HI = HIGH_WIDTH'((MODULUS - 1) / 10);
   localparam logic [3:0]            MAX_LO = 4'((MODULUS - 1) % 10);

   logic [3:0]            low_q, low_d;
   logic [HIGH_WIDTH-1:0] high_q, high_d;
   logic                  err_q, err_d;
   logic                  at_max, at_zero, load_ok;
   logic [7:0]            load_val;

   assign at_max  = (high_q == MAX_HI) && (low_q == MAX_LO);
   assign at_zero = (high_q == '0) && (low_q == 4'd0);

   // Preset is compared as a binary value; 8 bits covers 10*15+15.
   assign load_val = 8'(load_high_i) * 8'd10 + 8'(load_low_i);
   assign load_ok  = (load_low_i <= 4'd9) && (load_val < 8'(MODULUS));

   always_comb begin
      low_d  = low_q;
      high_d = high_q;
      err_d  = 1'b0;
      if (clear_i) begin
         low_d  = 4'd0;
         high_d = '0;
      end else if (load_i) begin
         if (load_ok) begin
            low_d  = load_low_i;
            high_d = load_high_i;
         end else begin
            err_d = 1'b1;
         end
      end else if (enable_i) begin
         if (up_down_i) begin
            if (at_max) begin
               low_d  = 4'd0;
               high_d = '0;
            end else if (low_q == 4'd9) begin
               low_d  = 4'd0;
               high_d = high_q + 1'b1;
            end else begin
               low_d = low_q + 4'd1;
            end
         end else begin
            if (low_q != 4'd0) begin
               low_d = low_q - 4'd1;
            end else if (high_q != '0) begin
               low_d  = 4'd9;
               high_d = high_q - 1'b1;
            end else begin
               low_d  = MAX_LO;
               high_d = MAX_HI;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         low_q  <= 4'd0;
         high_q <= '0;
         err_q  <= 1'b0;
      end else begin
         low_q  <= low_d;
         high_q <= high_d;
         err_q  <= err_d;
      end
   end

   assign low_digit_o   = low_q;
   assign high_digit_o  = high_q;
   assign load_err_o    = err_q;
   // Unregistered so the next stage steps on the same edge as this wrap.
   assign at_terminal_o = up_down_i ? at_max : at_zero;
   assign carry_out_o   = enable_i & at_terminal_o;

endmodule

// File: tb/tb_bcd_timer_modn.sv
// Directed bench: seconds (mod 60) cascaded into minutes (mod 60), plus a mod-24 instance.
module tb_bcd_timer_modn;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       en, ud, clr, ld;
   logic [3:0] ld_lo;
   logic [2:0] ld_hi;
   logic [3:0] lo;
   logic [2:0] hi;
   logic       at_t, co, lerr;

   logic       m_ld;
   logic [3:0] m_ld_lo, m_lo;
   logic [2:0] m_ld_hi, m_hi;
   logic       m_at, m_co, m_err;

   logic       t_en, t_ud, t_clr, t_ld;
   logic [3:0] t_ld_lo, t_lo;
   logic [1:0] t_ld_hi, t_hi;
   logic       t_at, t_co, t_err;

   int checks = 0;
   int errors = 0;

   bcd_timer_modn #(.MODULUS(60), .HIGH_WIDTH(3)) u_sec (
      .clk_i(clk), .reset_ni(rst_n), .enable_i(en), .up_down_i(ud), .clear_i(clr),
      .load_i(ld), .load_low_i(ld_lo), .load_high_i(ld_hi), .low_digit_o(lo),
      .high_digit_o(hi), .at_terminal_o(at_t), .carry_out_o(co), .load_err_o(lerr));

   bcd_timer_modn #(.MODULUS(60), .HIGH_WIDTH(3)) u_min (
      .clk_i(clk), .reset_ni(rst_n), .enable_i(co), .up_down_i(1'b1), .clear_i(1'b0),
      .load_i(m_ld), .load_low_i(m_ld_lo), .load_high_i(m_ld_hi), .low_digit_o(m_lo),
      .high_digit_o(m_hi), .at_terminal_o(m_at), .carry_out_o(m_co), .load_err_o(m_err));

   bcd_timer_modn #(.MODULUS(24), .HIGH_WIDTH(2)) u_hr (
      .clk_i(clk), .reset_ni(rst_n), .enable_i(t_en), .up_down_i(t_ud), .clear_i(t_clr),
      .load_i(t_ld), .load_low_i(t_ld_lo), .load_high_i(t_ld_hi), .low_digit_o(t_lo),
      .high_digit_o(t_hi), .at_terminal_o(t_at), .carry_out_o(t_co), .load_err_o(t_err));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Load the seconds counter with enable low, leaving it idle afterwards.
   task automatic preset_sec(input int h, input int l);
      en = 0; ld = 1; ld_hi = 3'(h); ld_lo = 4'(l);
      tick();
      ld = 0;
   endtask

   task automatic test_reset();
      rst_n = 0; en = 1; clr = 1; ld = 1; ud = 1; ld_hi = 3'd1; ld_lo = 4'd2;
      tick(); tick();
      checks++;
      if (hi !== 3'd0 || lo !== 4'd0) begin
         errors++; $display("FAIL reset_value: got %0d%0d want 00", hi, lo);
      end
      checks++;
      if (lerr !== 1'b0) begin
         errors++; $display("FAIL reset_err: got %b want 0", lerr);
      end
      checks++;
      if (m_hi !== 3'd0 || m_lo !== 4'd0 || t_hi !== 2'd0 || t_lo !== 4'd0) begin
         errors++; $display("FAIL reset_others: got min %0d%0d hr %0d%0d want 00", m_hi, m_lo, t_hi, t_lo);
      end
      en = 0; clr = 0; ld = 0;
      rst_n = 1;
      tick();
   endtask

   task automatic test_count_up();
      en = 1; ud = 1;
      for (int i = 0; i < 60; i++) begin
         #1;
         checks++;
         if (hi !== 3'(i / 10) || lo !== 4'(i % 10)) begin
            errors++; $display("FAIL up_step: got %0d%0d want %0d", hi, lo, i);
         end
         checks++;
         if (co !== (i == 59)) begin
            errors++; $display("FAIL up_carry at %0d: got %b want %b", i, co, i == 59);
         end
         @(posedge clk); #1;
      end
      #1;
      checks++;
      if (hi !== 3'd0 || lo !== 4'd0) begin
         errors++; $display("FAIL up_wrap: got %0d%0d want 00", hi, lo);
      end
      en = 0;
      tick();
   endtask

   task automatic test_count_down();
      en = 1; ud = 0;
      #1;
      checks++;
      if (co !== 1'b1 || at_t !== 1'b1) begin
         errors++; $display("FAIL down_borrow_at_00: got co=%b at=%b want 1 1", co, at_t);
      end
      tick();
      checks++;
      if (hi !== 3'd5 || lo !== 4'd9 || co !== 1'b0) begin
         errors++; $display("FAIL down_wrap: got %0d%0d co=%b want 59 co=0", hi, lo, co);
      end
      tick();
      checks++;
      if (hi !== 3'd5 || lo !== 4'd8) begin
         errors++; $display("FAIL down_step: got %0d%0d want 58", hi, lo);
      end
      preset_sec(5, 0);
      en = 1; ud = 0;
      tick();
      checks++;
      if (hi !== 3'd4 || lo !== 4'd9) begin
         errors++; $display("FAIL down_50_to_49: got %0d%0d want 49", hi, lo);
      end
      // direction flip takes effect on the very next enabled edge
      ud = 1;
      tick();
      checks++;
      if (hi !== 3'd5 || lo !== 4'd0) begin
         errors++; $display("FAIL dir_flip: got %0d%0d want 50", hi, lo);
      end
      en = 0;
   endtask

   task automatic test_preset();
      preset_sec(2, 5);
      checks++;
      if (hi !== 3'd2 || lo !== 4'd5 || lerr !== 1'b0) begin
         errors++; $display("FAIL load_25: got %0d%0d err=%b want 25 err=0", hi, lo, lerr);
      end
      preset_sec(6, 5);
      checks++;
      if (hi !== 3'd2 || lo !== 4'd5 || lerr !== 1'b1) begin
         errors++; $display("FAIL load_65_reject: got %0d%0d err=%b want 25 err=1", hi, lo, lerr);
      end
      tick();
      checks++;
      if (lerr !== 1'b0) begin
         errors++; $display("FAIL load_err_pulse: got %b want 0", lerr);
      end
      preset_sec(0, 10);
      checks++;
      if (hi !== 3'd2 || lo !== 4'd5 || lerr !== 1'b1) begin
         errors++; $display("FAIL load_lowA_reject: got %0d%0d err=%b want 25 err=1", hi, lo, lerr);
      end
      preset_sec(5, 9);
      checks++;
      if (hi !== 3'd5 || lo !== 4'd9 || lerr !== 1'b0) begin
         errors++; $display("FAIL load_59_edge: got %0d%0d err=%b want 59 err=0", hi, lo, lerr);
      end
   endtask

   task automatic test_priority();
      preset_sec(3, 0);
      en = 1; ud = 1; ld = 1; ld_hi = 3'd1; ld_lo = 4'd2;
      tick();
      checks++;
      if (hi !== 3'd1 || lo !== 4'd2) begin
         errors++; $display("FAIL load_over_enable: got %0d%0d want 12", hi, lo);
      end
      clr = 1; ld = 1; ld_hi = 3'd4; ld_lo = 4'd4;
      tick();
      checks++;
      if (hi !== 3'd0 || lo !== 4'd0 || lerr !== 1'b0) begin
         errors++; $display("FAIL clear_over_load: got %0d%0d err=%b want 00 err=0", hi, lo, lerr);
      end
      clr = 1; ld = 1; ld_hi = 3'd7; ld_lo = 4'd0;
      tick();
      checks++;
      if (lerr !== 1'b0) begin
         errors++; $display("FAIL clear_masks_bad_load: got err=%b want 0", lerr);
      end
      clr = 0; ld = 0; en = 0;
      preset_sec(3, 3);
      rst_n = 0; en = 1; clr = 1; ld = 1; ld_hi = 3'd1; ld_lo = 4'd1;
      tick();
      checks++;
      if (hi !== 3'd0 || lo !== 4'd0 || lerr !== 1'b0) begin
         errors++; $display("FAIL reset_wins: got %0d%0d err=%b want 00 err=0", hi, lo, lerr);
      end
      rst_n = 1; en = 0; clr = 0; ld = 0;
      tick();
   endtask

   task automatic test_hold();
      preset_sec(5, 9);
      en = 0; ud = 1;
      #1;
      checks++;
      if (at_t !== 1'b1 || co !== 1'b0) begin
         errors++; $display("FAIL hold_carry: got at=%b co=%b want 1 0", at_t, co);
      end
      tick();
      checks++;
      if (hi !== 3'd5 || lo !== 4'd9) begin
         errors++; $display("FAIL hold_value: got %0d%0d want 59", hi, lo);
      end
   endtask

   task automatic test_cascade();
      preset_sec(5, 9);
      m_ld = 1; m_ld_hi = 3'd0; m_ld_lo = 4'd7;
      tick();
      m_ld = 0;
      en = 1; ud = 1;
      #1;
      checks++;
      if (co !== 1'b1 || m_hi !== 3'd0 || m_lo !== 4'd7) begin
         errors++; $display("FAIL cascade_pre: got co=%b min=%0d%0d want co=1 min=07", co, m_hi, m_lo);
      end
      tick();
      checks++;
      if (hi !== 3'd0 || lo !== 4'd0 || m_hi !== 3'd0 || m_lo !== 4'd8) begin
         errors++; $display("FAIL cascade_edge: got %0d%0d:%0d%0d want 08:00", m_hi, m_lo, hi, lo);
      end
      tick();
      checks++;
      if (m_lo !== 4'd8 || lo !== 4'd1) begin
         errors++; $display("FAIL cascade_after: got min_lo=%0d sec_lo=%0d want 8 1", m_lo, lo);
      end
      en = 0;
   endtask

   task automatic test_mod24();
      t_en = 0; t_ld = 1; t_ld_hi = 2'd2; t_ld_lo = 4'd4;
      tick();
      checks++;
      if (t_err !== 1'b1 || t_hi !== 2'd0 || t_lo !== 4'd0) begin
         errors++; $display("FAIL hr_load24_reject: got %0d%0d err=%b want 00 err=1", t_hi, t_lo, t_err);
      end
      t_ld_lo = 4'd2;
      tick();
      t_ld = 0; t_en = 1; t_ud = 1;
      tick();
      #1;
      checks++;
      if (t_hi !== 2'd2 || t_lo !== 4'd3 || t_co !== 1'b1) begin
         errors++; $display("FAIL hr_at_23: got %0d%0d co=%b want 23 co=1", t_hi, t_lo, t_co);
      end
      tick();
      checks++;
      if (t_hi !== 2'd0 || t_lo !== 4'd0 || t_co !== 1'b0) begin
         errors++; $display("FAIL hr_wrap: got %0d%0d co=%b want 00 co=0", t_hi, t_lo, t_co);
      end
      t_ud = 0;
      tick();
      checks++;
      if (t_hi !== 2'd2 || t_lo !== 4'd3) begin
         errors++; $display("FAIL hr_down_wrap: got %0d%0d want 23", t_hi, t_lo);
      end
      t_en = 0;
   endtask

   initial begin
      rst_n = 0; en = 0; ud = 1; clr = 0; ld = 0; ld_lo = '0; ld_hi = '0;
      m_ld = 0; m_ld_lo = '0; m_ld_hi = '0;
      t_en = 0; t_ud = 1; t_clr = 0; t_ld = 0; t_ld_lo = '0; t_ld_hi = '0;
      test_reset();
      test_count_up();
      test_count_down();
      test_preset();
      test_priority();
      test_hold();
      test_cascade();
      test_mod24();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bcd_timer_modn.md
Name: bcd_timer_modn

Overview:
- Parametrised successor to the fixed 0-59 two-digit timer: a two-digit BCD counter, modulo MODULUS, counting up or down.
- Adds synchronous clear, BCD preset load with range checking, and a same-cycle carry/borrow output for cascading (seconds -> minutes -> hours).
- Driven by an external tick on enable (pre-divided clock-enable). It is not a clock.

Parameters:
- MODULUS, 60, count range 0..MODULUS-1. Legal range 2..100.
- HIGH_WIDTH, 3, width of the tens digit. Must hold (MODULUS-1)/10. Use 4 for MODULUS > 80.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- enable  input  1  count tick; one step per cycle while high.
- up_down  input  1  1 = count up, 0 = count down; sampled each enabled cycle.
- clear  input  1  synchronous clear to 00.
- load  input  1  synchronous preset from load_high/load_low.
- load_low  input  4  BCD units preset.
- load_high  input  HIGH_WIDTH  BCD tens preset.
- low_digit  output  4  registered units digit (0-9).
- high_digit  output  HIGH_WIDTH  registered tens digit.
- at_terminal  output  1  combinational; 1 when the count equals the terminal value for the current up_down.
- carry_out  output  1  combinational; enable & at_terminal. Drives the next stage's enable.
- load_err  output  1  registered one-cycle pulse; the preceding load was rejected.

Behaviour:
- Value V = 10*high_digit + low_digit. Invariants at all times: V < MODULUS and low_digit <= 9.
- Reset (reset==0 at a clk edge): low_digit=0, high_digit=0, load_err=0. No count in that cycle.
- Priority, highest first: reset, clear, load, enable.
- Clear:
  - Next V = 0.
  - load_err = 0.
  - enable is ignored that cycle.
- Load:
  - Accepted if load_low <= 9 and 10*load_high + load_low < MODULUS. Next V = the preset value.
  - Otherwise the count holds and load_err = 1 on the next cycle.
  - enable is ignored that cycle in both cases.
- Up count (enable=1, up_down=1):
  - low<9 and V != MODULUS-1: low+1.
  - low==9 and V != MODULUS-1: low=0, high+1.
  - V == MODULUS-1: wraps to 00.
- Down count (enable=1, up_down=0):
  - low>0: low-1.
  - low==0 and V>0: low=9, high-1.
  - V==0: wraps to MODULUS-1, i.e. high=(MODULUS-1)/10, low=(MODULUS-1)%10.
- Terminal value: MODULUS-1 when up_down=1, 0 when up_down=0.
- at_terminal reflects the current registered count and the live up_down input.
- carry_out is combinational, with no register stage, so a cascaded stage advances on the same edge as the wrap.
- enable=0 holds the count. carry_out=0 while enable=0, even at terminal.
- Latency: digits update on the edge after an enabled/clear/load cycle. No output pipeline lag.
- Changing up_down mid-count takes effect on the next enabled edge. There is no turnaround penalty.
- load_err is high only for the single cycle after a rejected load. It is 0 otherwise, including after an accepted load.
- reset asserted mid-count or coincident with load/clear/enable: reset wins and the outputs go to 00.

Test Plan:
- MODULUS=60, reset then enable=1, up_down=1 for 60 cycles -> digits step 00..59 then 00; carry_out=1 only in the cycle showing 59; units roll 9->0 with tens+1 at 09->10, 19->20, etc.
- From 00, up_down=0, enable=1 -> next 59 with carry_out=1 in the 00 cycle; then 58; at 50 -> 49.
- Preset cases:
  - load=1 with high=2, low=5 -> 25, load_err=0.
  - load with high=6, low=5 (65 >= 60) -> count holds, load_err pulses 1 for one cycle.
  - load with low=4'hA -> rejected, load_err=1.
- Same-cycle priority:
  - load=1 and enable=1 at 30, preset 12 -> 12, no increment.
  - clear=1 and load=1 -> 00.
  - reset=0 with clear/load/enable all high -> 00, load_err=0.
- MODULUS=24 instance counting up -> 23 wraps to 00, carry at 23.
- Cascade: two instances with the seconds carry_out on the minutes enable -> seconds 59 with minutes 07 becomes 00 and 08 on the same edge.
- Hold: enable=0 at 59 -> carry_out=0, count stays 59.
